nibble_packer: RTL and testbench

- Downstream consumer of the 4-bit nibble FIFO. Pops nibbles through the FIFO's read-enable/empty interface and assembles NIBBLES nibbles into one output word.
- Presents each word on a valid/ready handshake to the next stage.
- Supports a flush request that emits a partial word and reports its nibble count.
- Tracks the number of words delivered.

---
 rtl/nibble_packer.sv | 137 +++++++++++++
 tb/tb_nibble_packer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_packer.sv
// nibble_packer: pops 4-bit nibbles from a FIFO read port and assembles them into
// NIBBLES-wide words. Each word is offered downstream on a valid/ready handshake.
// A flush request emits a partially filled word.
module nibble_packer #(
    parameter int unsigned NIBBLES   = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [3:0]             fifo_data,
    input  logic                   flush,
    output logic [4*NIBBLES-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       out_nibbles,
    output logic [15:0]            word_cnt,
    output logic                   busy
);

    localparam int unsigned       DATA_W  = 4 * NIBBLES;
    localparam logic [CNT_W-1:0]  NIB_MAX = CNT_W'(NIBBLES);

    typedef enum logic {
        S_FILL = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t              r_state,      w_state_nx;
    logic [CNT_W-1:0]    r_issued,     w_issued_nx;
    logic [CNT_W-1:0]    r_captured,   w_captured_nx;
    logic [CNT_W-1:0]    r_nibbles,    w_nibbles_nx;
    logic                r_rd_pending, w_rd_pending_nx;
    logic                r_flush_req,  w_flush_req_nx;
    logic [DATA_W-1:0]   r_data,       w_data_nx;
    logic [15:0]         r_word_cnt,   w_word_cnt_nx;
    logic                w_rd_en;

    // Pop whenever there is room, data is available and no flush is in progress.
    // Gated by reset so no pop request is presented while the block is held in reset.
    assign w_rd_en = rst && (r_state == S_FILL) && !fifo_empty &&
                     (r_issued < NIB_MAX) && !r_flush_req && !flush;

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_FILL;
            r_issued     <= '0;
            r_captured   <= '0;
            r_nibbles    <= '0;
            r_rd_pending <= 1'b0;
            r_flush_req  <= 1'b0;
            r_data       <= '0;
            r_word_cnt   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_issued     <= w_issued_nx;
            r_captured   <= w_captured_nx;
            r_nibbles    <= w_nibbles_nx;
            r_rd_pending <= w_rd_pending_nx;
            r_flush_req  <= w_flush_req_nx;
            r_data       <= w_data_nx;
            r_word_cnt   <= w_word_cnt_nx;
        end
    end

    // Next-state logic: fill slots from returning reads, then hold the word until accepted.
    always_comb begin
        w_state_nx      = r_state;
        w_issued_nx     = r_issued;
        w_captured_nx   = r_captured;
        w_nibbles_nx    = r_nibbles;
        w_rd_pending_nx = w_rd_en;
        w_flush_req_nx  = r_flush_req;
        w_data_nx       = r_data;
        w_word_cnt_nx   = r_word_cnt;

        case (r_state)
            S_FILL: begin
                if (w_rd_en) begin
                    w_issued_nx = r_issued + CNT_W'(1);
                end
                if (flush) begin
                    w_flush_req_nx = 1'b1;
                end
                if (r_rd_pending) begin
                    // Data returned for the previous pop lands in the next free slot.
                    for (int unsigned k = 0; k < NIBBLES; k++) begin
                        if (r_captured == CNT_W'(k)) begin
                            if (MSB_FIRST != 0) begin
                                w_data_nx[4*(NIBBLES-1-k) +: 4] = fifo_data;
                            end else begin
                                w_data_nx[4*k +: 4] = fifo_data;
                            end
                        end
                    end
                    w_captured_nx = r_captured + CNT_W'(1);
                    if (w_captured_nx == NIB_MAX) begin
                        w_state_nx   = S_EMIT;
                        w_nibbles_nx = NIB_MAX;
                    end
                end else if (r_flush_req) begin
                    // No read in flight: emit whatever has been gathered, or drop an empty flush.
                    if (r_captured != '0) begin
                        w_state_nx   = S_EMIT;
                        w_nibbles_nx = r_captured;
                    end else begin
                        w_flush_req_nx = 1'b0;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_word_cnt_nx  = r_word_cnt + 16'(1);
                    w_issued_nx    = '0;
                    w_captured_nx  = '0;
                    w_flush_req_nx = 1'b0;
                    w_data_nx      = '0;
                    w_state_nx     = S_FILL;
                end
            end
            default: begin
                w_state_nx = S_FILL;
            end
        endcase
    end

    assign fifo_rd_en  = w_rd_en;
    assign out_data    = r_data;
    assign out_valid   = (r_state == S_EMIT);
    assign out_nibbles = r_nibbles;
    assign word_cnt    = r_word_cnt;
    assign busy        = (r_captured != '0) || r_rd_pending || (r_state == S_EMIT);

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: two instances (LSB-first and MSB-first) share one FIFO model.
module tb_nibble_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fifo_data;
    logic        flush;
    logic        out_ready;
    wire         fifo_empty;
    wire         rd0, rd1;
    wire  [15:0] od0, od1;
    wire         ov0, ov1;
    wire  [3:0]  on0, on1;
    wire  [15:0] wc0, wc1;
    wire         bz0, bz1;

    int total = 0;
    int bad   = 0;
    int exp_words = 0;

    // FIFO model: the stimulus writes wp, the pop process writes rp.
    logic [3:0] mem [0:1023];
    int wp = 0;
    int rp = 0;
    bit rd_empty_viol = 1'b0;

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    // Pop on rd0; data appears the cycle after the request.
    always @(posedge clk) begin
        if (rd0 && fifo_empty) rd_empty_viol <= 1'b1;
        if (rd0 && !fifo_empty) begin
            fifo_data <= mem[rp % 1024];
            rp <= rp + 1;
        end
    end

    nibble_packer #(.NIBBLES(4), .CNT_W(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd0),
        .fifo_data(fifo_data), .flush(flush), .out_data(od0), .out_valid(ov0),
        .out_ready(out_ready), .out_nibbles(on0), .word_cnt(wc0), .busy(bz0)
    );

    nibble_packer #(.NIBBLES(4), .CNT_W(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd1),
        .fifo_data(fifo_data), .flush(flush), .out_data(od1), .out_valid(ov1),
        .out_ready(out_ready), .out_nibbles(on1), .word_cnt(wc1), .busy(bz1)
    );

    // Expected word: nibble k weighted by 16^k (LSB-first) or 16^(3-k) (MSB-first).
    function automatic logic [15:0] pack(input logic [3:0] v0, input logic [3:0] v1,
                                         input logic [3:0] v2, input logic [3:0] v3,
                                         input int cnt, input bit msb);
        logic [3:0] v [4];
        int w;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        w = 0;
        for (int k = 0; k < cnt; k++) begin
            w = w + int'(v[k]) * (1 << (4 * (msb ? (3 - k) : k)));
        end
        return 16'(w);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] v);
        mem[wp % 1024] = v;
        wp = wp + 1;
    endtask

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_data = 4'h0;
        repeat (3) tick();
        total++;
        if ({od0, ov0, on0, wc0, bz0, rd0, od1, bz1} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h/%b/%h/%h/%b/%b exp=0", od0, ov0, on0, wc0, bz0, rd0);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({ov0, bz0, wc0} !== '0) begin
            bad++; $display("FAIL reset_release got valid=%b busy=%b cnt=%h exp 0", ov0, bz0, wc0);
        end
    endtask

    task automatic test_basic;
        logic [11:0] rdmap;
        int first_v;
        int rd_diff;
        logic [15:0] d0, d1, wcv;
        logic [3:0] n0, n1;
        rdmap = '0; first_v = -1; rd_diff = 0;
        d0 = '0; d1 = '0; wcv = '0; n0 = '0; n1 = '0;
        out_ready = 1'b1;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        #1;
        for (int w = 0; w < 12; w++) begin
            rdmap[w] = rd0;
            if (rd0 !== rd1) rd_diff++;
            if (ov0 === 1'b1 && first_v < 0) begin
                first_v = w; d0 = od0; d1 = od1; n0 = on0; n1 = on1; wcv = wc0;
            end
            tick();
        end
        total++; if (rdmap !== 12'h00F) begin bad++; $display("FAIL basic_rd_en got=%b exp=%b", rdmap, 12'h00F); end
        total++; if (rd_diff !== 0) begin bad++; $display("FAIL basic_rd_en_match got=%0d exp=0", rd_diff); end
        total++; if (first_v !== 5) begin bad++; $display("FAIL basic_latency got=%0d exp=5", first_v); end
        total++; if (d0 !== 16'h4321) begin bad++; $display("FAIL basic_data_lsb got=%h exp=4321", d0); end
        total++; if (d1 !== 16'h1234) begin bad++; $display("FAIL basic_data_msb got=%h exp=1234", d1); end
        total++; if (n0 !== 4'd4 || n1 !== 4'd4) begin bad++; $display("FAIL basic_nibbles got=%0d/%0d exp=4", n0, n1); end
        total++; if (wcv !== 16'd0) begin bad++; $display("FAIL basic_cnt_before got=%0d exp=0", wcv); end
        exp_words = 1;
        total++; if (wc0 !== 16'd1 || wc1 !== 16'd1 || ov0 !== 1'b0) begin
            bad++; $display("FAIL basic_cnt_after got=%0d/%0d valid=%b exp=1 valid=0", wc0, wc1, ov0);
        end
    endtask

    task automatic test_backpressure;
        int stall_bad;
        stall_bad = 0;
        out_ready = 1'b0;
        push(4'hA); push(4'hB); push(4'hC); push(4'hD);
        push(4'hE); push(4'hF); push(4'h0); push(4'h1);
        for (int i = 0; i < 20 && ov0 !== 1'b1; i++) tick();
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL bp_first_timeout got valid=%b exp=1", ov0); end
        for (int i = 0; i < 10; i++) begin
            if (ov0 !== 1'b1 || od0 !== 16'hDCBA || od1 !== 16'hABCD || rd0 !== 1'b0) stall_bad++;
            tick();
        end
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles exp=0", stall_bad); end
        out_ready = 1'b1;
        tick();
        exp_words++;
        for (int i = 0; i < 20 && ov0 !== 1'b1; i++) tick();
        total++; if (od0 !== 16'h10FE || od1 !== 16'hEF01 || ov0 !== 1'b1) begin
            bad++; $display("FAIL bp_second got=%h/%h valid=%b exp=10fe/ef01", od0, od1, ov0);
        end
        tick();
        exp_words++;
        total++; if (wc0 !== 16'(exp_words) || ov0 !== 1'b0) begin
            bad++; $display("FAIL bp_cnt got=%0d valid=%b exp=%0d", wc0, ov0, exp_words);
        end
    endtask

    task automatic test_flush_partial;
        logic [3:0] r [4];
        int vseen;
        out_ready = 1'b1;
        push(4'h5); push(4'h6);
        repeat (4) tick();
        total++; if (ov0 !== 1'b0 || bz0 !== 1'b1) begin bad++; $display("FAIL fl_stall got valid=%b busy=%b exp 0/1", ov0, bz0); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 10 && ov0 !== 1'b1; i++) tick();
        total++; if (od0 !== 16'h0065 || od1 !== 16'h5600 || on0 !== 4'd2 || ov0 !== 1'b1) begin
            bad++; $display("FAIL fl_partial got=%h/%h n=%0d valid=%b exp=0065/5600 n=2", od0, od1, on0, ov0);
        end
        tick();
        exp_words++;
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vseen = 0;
        for (int i = 0; i < 8; i++) begin
            if (ov0 === 1'b1) vseen++;
            tick();
        end
        total++; if (vseen !== 0 || bz0 !== 1'b0) begin bad++; $display("FAIL fl_empty got valid cycles=%0d busy=%b exp 0", vseen, bz0); end
        for (int k = 0; k < 4; k++) begin r[k] = 4'($urandom); push(r[k]); end
        for (int i = 0; i < 12 && ov0 !== 1'b1; i++) tick();
        total++; if (od0 !== pack(r[0], r[1], r[2], r[3], 4, 0) || on0 !== 4'd4 || ov0 !== 1'b1) begin
            bad++; $display("FAIL fl_after_empty got=%h n=%0d exp=%h n=4", od0, on0, pack(r[0], r[1], r[2], r[3], 4, 0));
        end
        tick();
        exp_words++;
    endtask

    task automatic test_flush_pending;
        logic [3:0] n [7];
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin n[k] = 4'($urandom); push(n[k]); end
        repeat (3) tick();
        flush = 1'b1;
        #1;
        total++; if (rd0 !== 1'b0) begin bad++; $display("FAIL fp_rd_block got=%b exp=0", rd0); end
        tick();
        flush = 1'b0;
        for (int i = 0; i < 10 && ov0 !== 1'b1; i++) tick();
        total++; if (od0 !== pack(n[0], n[1], n[2], 4'h0, 3, 0) || od1 !== pack(n[0], n[1], n[2], 4'h0, 3, 1) ||
                     on0 !== 4'd3 || ov0 !== 1'b1) begin
            bad++; $display("FAIL fp_word got=%h/%h n=%0d exp=%h n=3", od0, od1, on0, pack(n[0], n[1], n[2], 4'h0, 3, 0));
        end
        tick();
        exp_words++;
        n[5] = 4'($urandom); n[6] = 4'($urandom);
        push(n[5]); push(n[6]);
        for (int i = 0; i < 12 && ov0 !== 1'b1; i++) tick();
        total++; if (od0 !== pack(n[3], n[4], n[5], n[6], 4, 0) || on0 !== 4'd4 || ov0 !== 1'b1) begin
            bad++; $display("FAIL fp_next got=%h n=%0d exp=%h", od0, on0, pack(n[3], n[4], n[5], n[6], 4, 0));
        end
        tick();
        exp_words++;
    endtask

    task automatic test_async_reset;
        logic [3:0] m [4];
        logic [3:0] x, y0, y1, y2;
        out_ready = 1'b1;
        push(4'($urandom_range(1, 15))); push(4'($urandom_range(1, 15)));
        repeat (4) tick();
        #3;
        rst = 1'b0;
        #1;
        total++; if ({od0, ov0, on0, wc0, bz0, rd0} !== '0) begin
            bad++; $display("FAIL ar_midword got=%h/%b/%0d/%0d/%b/%b exp=0", od0, ov0, on0, wc0, bz0, rd0);
        end
        #2;
        rst = 1'b1;
        tick();
        exp_words = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin m[k] = 4'($urandom); push(m[k]); end
        x = 4'($urandom); push(x);
        for (int i = 0; i < 12 && ov0 !== 1'b1; i++) tick();
        total++; if (od0 !== pack(m[0], m[1], m[2], m[3], 4, 0) || ov0 !== 1'b1 || wc0 !== 16'd0) begin
            bad++; $display("FAIL ar_post_word got=%h valid=%b cnt=%0d exp=%h cnt=0", od0, ov0, wc0, pack(m[0], m[1], m[2], m[3], 4, 0));
        end
        #3;
        rst = 1'b0;
        #1;
        total++; if ({od0, ov0, on0, bz0, rd0, ov1, bz1} !== '0) begin
            bad++; $display("FAIL ar_midemit got=%h/%b/%0d/%b/%b exp=0", od0, ov0, on0, bz0, rd0);
        end
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        y0 = 4'($urandom); y1 = 4'($urandom); y2 = 4'($urandom);
        push(y0); push(y1); push(y2);
        tick();
        for (int i = 0; i < 12 && ov0 !== 1'b1; i++) tick();
        total++; if (od0 !== pack(x, y0, y1, y2, 4, 0) || ov0 !== 1'b1 || wc0 !== 16'd0) begin
            bad++; $display("FAIL ar_restart got=%h cnt=%0d exp=%h cnt=0", od0, wc0, pack(x, y0, y1, y2, 4, 0));
        end
        tick();
        exp_words = 1;
        total++; if (wc0 !== 16'd1 || wc1 !== 16'd1) begin bad++; $display("FAIL ar_cnt got=%0d/%0d exp=1", wc0, wc1); end
    endtask

    task automatic test_random;
        logic [3:0] expq [$];
        logic [3:0] v [4];
        logic [15:0] prev_od;
        bit prev_hold;
        int pushed, got, stab_bad, rd_diff;
        pushed = 0; got = 0; stab_bad = 0; rd_diff = 0; prev_hold = 1'b0; prev_od = '0;
        for (int c = 0; c < 3000 && got < 10; c++) begin
            if (pushed < 40 && $urandom_range(0, 2) != 0) begin
                v[0] = 4'($urandom); push(v[0]); expq.push_back(v[0]); pushed++;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (rd0 !== rd1) rd_diff++;
            if (prev_hold && (ov0 !== 1'b1 || od0 !== prev_od)) stab_bad++;
            if (ov0 === 1'b1 && out_ready === 1'b1) begin
                for (int k = 0; k < 4; k++) v[k] = expq.pop_front();
                total++;
                if (od0 !== pack(v[0], v[1], v[2], v[3], 4, 0) || od1 !== pack(v[0], v[1], v[2], v[3], 4, 1)) begin
                    bad++; $display("FAIL rnd_word%0d got=%h/%h exp=%h/%h", got, od0, od1,
                                    pack(v[0], v[1], v[2], v[3], 4, 0), pack(v[0], v[1], v[2], v[3], 4, 1));
                end
                got++; exp_words++;
            end
            prev_hold = (ov0 === 1'b1) && !out_ready;
            prev_od = od0;
            tick();
        end
        total++; if (got !== 10) begin bad++; $display("FAIL rnd_timeout got=%0d words exp=10", got); end
        total++; if (stab_bad !== 0 || rd_diff !== 0) begin bad++; $display("FAIL rnd_stable got=%0d/%0d exp=0", stab_bad, rd_diff); end
        total++; if (wc0 !== 16'(exp_words)) begin bad++; $display("FAIL rnd_cnt got=%0d exp=%0d", wc0, exp_words); end
        total++; if (rd_empty_viol !== 1'b0) begin bad++; $display("FAIL rd_while_empty got=1 exp=0"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_partial();
        test_flush_pending();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
